// File: rtl/conv3x3_rgb888.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv3x3_rgb888                                               |
// | Description : Per-channel 3x3 filter (bypass / blur / sharpen / edge) with |
// |               output BRAM write-address and end-of-frame generation.       |
// |               Define CONV_EDGE_EN to build the Laplacian edge mode.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module conv3x3_rgb888 #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 17,
    parameter int OUT_DEPTH = 129060
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iWin0,
    input  logic [DATA_W-1:0] iWin1,
    input  logic [DATA_W-1:0] iWin2,
    input  logic [DATA_W-1:0] iWin3,
    input  logic [DATA_W-1:0] iWin4,
    input  logic [DATA_W-1:0] iWin5,
    input  logic [DATA_W-1:0] iWin6,
    input  logic [DATA_W-1:0] iWin7,
    input  logic [DATA_W-1:0] iWin8,
    input  logic [1:0]        iMode,
    output logic [DATA_W-1:0] oPixel,
    output logic              oValid,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oFrameDone
);

    localparam int                CH     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(OUT_DEPTH - 1);

    logic [ADDR_W-1:0] in_cnt_d, in_cnt_q;
    logic [1:0]        mode_act_d, mode_act_q;
    logic [1:0]        mode_sel;

    logic [DATA_W-1:0] win_d [9];
    logic [DATA_W-1:0] win_q [9];
    logic              v1_q, v2_q;
    logic [1:0]        mode1_q, mode2_q;

    logic [9:0]        corner_d [CH];
    logic [9:0]        corner_q [CH];
    logic [9:0]        edge_d   [CH];
    logic [9:0]        edge_q   [CH];
    logic [7:0]        cent_d   [CH];
    logic [7:0]        cent_q   [CH];

    logic [DATA_W-1:0] pixel_d, pixel_q;
    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic              done_d, done_q;

    // Stage 1: mode capture at frame start, window register.
    always_comb begin
        win_d[0] = iWin0;
        win_d[1] = iWin1;
        win_d[2] = iWin2;
        win_d[3] = iWin3;
        win_d[4] = iWin4;
        win_d[5] = iWin5;
        win_d[6] = iWin6;
        win_d[7] = iWin7;
        win_d[8] = iWin8;

        mode_sel = (in_cnt_q == '0) ? iMode : mode_act_q;
`ifndef CONV_EDGE_EN
        if (mode_sel == 2'd3) begin
            mode_sel = 2'd0;
        end
`endif
        in_cnt_d   = in_cnt_q;
        mode_act_d = mode_act_q;
        if (iValid) begin
            in_cnt_d   = (in_cnt_q == C_LAST) ? '0 : in_cnt_q + ADDR_W'(1);
            mode_act_d = mode_sel;
        end
    end

    // Stage 2: per-channel corner sum, edge-neighbour sum and centre.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            corner_d[c] = 10'(win_q[0][c*8 +: 8]) + 10'(win_q[2][c*8 +: 8])
                        + 10'(win_q[6][c*8 +: 8]) + 10'(win_q[8][c*8 +: 8]);
            edge_d[c]   = 10'(win_q[1][c*8 +: 8]) + 10'(win_q[3][c*8 +: 8])
                        + 10'(win_q[5][c*8 +: 8]) + 10'(win_q[7][c*8 +: 8]);
            cent_d[c]   = win_q[4][c*8 +: 8];
        end
    end

    // Stage 3: combine, scale/clamp, and advance the write address.
    always_comb begin : p_stage3
        logic [11:0]        blur;
        logic signed [12:0] sh;
        logic signed [12:0] ed;
        logic signed [12:0] ea;
        pixel_d = '0;
        for (int c = 0; c < CH; c++) begin
            blur = 12'(corner_q[c]) + {1'b0, edge_q[c], 1'b0} + {2'b00, cent_q[c], 2'b00};
            sh   = $signed(13'({cent_q[c], 2'b00}) + 13'(cent_q[c]) - 13'(edge_q[c]));
            ed   = $signed(13'({cent_q[c], 3'b000}) - 13'(corner_q[c]) - 13'(edge_q[c]));
            ea   = (ed < 0) ? -ed : ed;
            case (mode2_q)
                2'd1: pixel_d[c*8 +: 8] = blur[11:4];
                2'd2: begin
                    if (sh < 0)                pixel_d[c*8 +: 8] = 8'd0;
                    else if (sh > 13'sd255)    pixel_d[c*8 +: 8] = 8'd255;
                    else                       pixel_d[c*8 +: 8] = sh[7:0];
                end
`ifdef CONV_EDGE_EN
                2'd3: pixel_d[c*8 +: 8] = (ea > 13'sd255) ? 8'd255 : ea[7:0];
`endif
                default: pixel_d[c*8 +: 8] = cent_q[c];
            endcase
        end
        if (!v2_q) begin
            pixel_d = '0;
        end

        valid_d   = v2_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        done_d    = 1'b0;
        if (v2_q) begin
            addr_d    = wr_addr_q;
            wr_addr_d = (wr_addr_q == C_LAST) ? '0 : wr_addr_q + ADDR_W'(1);
            done_d    = (wr_addr_q == C_LAST);
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            in_cnt_q   <= '0;
            mode_act_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            mode1_q    <= '0;
            mode2_q    <= '0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            for (int c = 0; c < CH; c++) begin
                corner_q[c] <= '0;
                edge_q[c]   <= '0;
                cent_q[c]   <= '0;
            end
            pixel_q    <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            mode_act_q <= mode_act_d;
            v1_q       <= iValid;
            v2_q       <= v1_q;
            mode1_q    <= mode_sel;
            mode2_q    <= mode1_q;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
            for (int c = 0; c < CH; c++) begin
                corner_q[c] <= corner_d[c];
                edge_q[c]   <= edge_d[c];
                cent_q[c]   <= cent_d[c];
            end
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            done_q     <= done_d;
        end
    end

    assign oPixel     = pixel_q;
    assign oValid     = valid_q;
    assign oWe        = valid_q;
    assign oAddr      = addr_q;
    assign oFrameDone = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_rgb888.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv3x3_rgb888                                            |
// | Description : Scoreboard bench for conv3x3_rgb888 with a 4-window frame.   |
// |               Edge expectations follow CONV_EDGE_EN.                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_conv3x3_rgb888;

    logic        iClk;
    logic        iRst;
    logic        iValid;
    logic [23:0] iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8;
    logic [1:0]  iMode;
    logic [23:0] oPixel;
    logic        oValid;
    logic        oWe;
    logic [16:0] oAddr;
    logic        oFrameDone;

    conv3x3_rgb888 #(
        .DATA_W   (24),
        .ADDR_W   (17),
        .OUT_DEPTH(4)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .iWin0     (iWin0),
        .iWin1     (iWin1),
        .iWin2     (iWin2),
        .iWin3     (iWin3),
        .iWin4     (iWin4),
        .iWin5     (iWin5),
        .iWin6     (iWin6),
        .iWin7     (iWin7),
        .iWin8     (iWin8),
        .iMode     (iMode),
        .oPixel    (oPixel),
        .oValid    (oValid),
        .oWe       (oWe),
        .oAddr     (oAddr),
        .oFrameDone(oFrameDone)
    );

    typedef struct {
        logic [23:0] pix;
        logic [16:0] addr;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   exp_wr = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // c = centre, n = four edge neighbours, k = four corners, e = expected pixel
    task automatic send(input logic [23:0] c, input logic [23:0] n, input logic [23:0] k,
                        input logic [1:0] m, input logic [23:0] e);
        exp_t x;
        @(posedge iClk);
        #1;
        iValid = 1'b1;
        iMode  = m;
        iWin4  = c;
        iWin1  = n; iWin3 = n; iWin5 = n; iWin7 = n;
        iWin0  = k; iWin2 = k; iWin6 = k; iWin8 = k;
        x.pix  = e;
        x.addr = 17'(exp_wr);
        x.done = (exp_wr == 3);
        x.cyc  = cyc;
        sbq.push_back(x);
        exp_wr = (exp_wr + 1) % 4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
            iValid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(posedge iClk);
            t++;
        end
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge iClk) begin
        exp_t e;
        check("we_eq_valid", 32'(oWe), 32'(oValid));
        if (oValid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'(oValid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("pixel", 32'(oPixel), 32'(e.pix));
                check("addr", 32'(oAddr), 32'(e.addr));
                check("frame_done", 32'(oFrameDone), 32'(e.done));
                check("latency", 32'(cyc - e.cyc), 32'd3);
            end
        end else begin
            check("idle_pixel_zero", 32'(oPixel), 32'd0);
            check("idle_done_zero", 32'(oFrameDone), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] e3a, e3b, e3c, e3d;
`ifdef CONV_EDGE_EN
        e3a = 24'hFFFFFF; e3b = 24'hFFFFFF; e3c = 24'h000000; e3d = 24'h0C0000;
`else
        e3a = 24'h000000; e3b = 24'h202020; e3c = 24'h010203; e3d = 24'h050000;
`endif
        iRst   = 1'b0;
        iValid = 1'b0;
        iMode  = 2'd0;
        {iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8} = '0;

        repeat (3) @(negedge iClk);
        check("rst_pixel", 32'(oPixel), 32'd0);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_we", 32'(oWe), 32'd0);
        check("rst_addr", 32'(oAddr), 32'd0);
        check("rst_done", 32'(oFrameDone), 32'd0);
        @(posedge iClk);
        #1;
        iRst = 1'b1;

        // Bypass: four back-to-back frames, centre selected
        for (int i = 1; i <= 16; i++) begin
            send(24'(i), 24'h123456, 24'hABCDEF, 2'd0, 24'(i));
        end

        // Blur
        send(24'h808080, 24'h808080, 24'h808080, 2'd1, 24'h808080);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd1, 24'h3F0000);
        send(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2'd1, 24'hFFFFFF);
        send(24'h000000, 24'h000000, 24'h100000, 2'd1, 24'h040000);

        // Sharpen with clamping
        send(24'hFFFFFF, 24'h000000, 24'h000000, 2'd2, 24'hFFFFFF);
        send(24'h000000, 24'hFFFFFF, 24'h000000, 2'd2, 24'h000000);
        send(24'h101010, 24'h101010, 24'h0000FF, 2'd2, 24'h101010);
        send(24'h0A0000, 24'h010000, 24'h000000, 2'd2, 24'h2E0000);

        // Edge (bypass when the edge mode is not built)
        send(24'h000000, 24'h202020, 24'h202020, 2'd3, e3a);
        send(24'h202020, 24'h000000, 24'h000000, 2'd3, e3b);
        send(24'h010203, 24'h010203, 24'h010203, 2'd3, e3c);
        send(24'h050000, 24'h040000, 24'h030000, 2'd3, e3d);
        idle(2);

        // Mid-frame mode change only applies at the next frame start
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd0, 24'hFF0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd0, 24'hFF0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd1, 24'hFF0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd1, 24'hFF0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd1, 24'h3F0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd1, 24'h3F0000);
        idle(2);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd1, 24'h3F0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd0, 24'h3F0000);
        send(24'hFF0000, 24'h000000, 24'h000000, 2'd0, 24'hFF0000);
        idle(1);
        drain();

        // Reset with two windows in flight, mid-frame
        send(24'h111111, 24'h000000, 24'h000000, 2'd0, 24'h111111);
        send(24'h222222, 24'h000000, 24'h000000, 2'd0, 24'h222222);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iRst   = 1'b0;
        sbq.delete();
        exp_wr = 0;
        @(negedge iClk);
        check("midrst_pixel", 32'(oPixel), 32'd0);
        check("midrst_valid", 32'(oValid), 32'd0);
        check("midrst_addr", 32'(oAddr), 32'd0);
        check("midrst_done", 32'(oFrameDone), 32'd0);
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        idle(4);

        // New frame after reset recaptures the mode and restarts at address 0
        send(24'hFFFFFF, 24'h000000, 24'h000000, 2'd2, 24'hFFFFFF);
        send(24'h0A0000, 24'h010000, 24'h000000, 2'd0, 24'h2E0000);
        send(24'h000000, 24'hFFFFFF, 24'h000000, 2'd0, 24'h000000);
        send(24'h101010, 24'h101010, 24'h0000FF, 2'd0, 24'h101010);
        idle(1);
        drain();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
